// File: rtl/pc_sequencer.sv
// Program-flow controller: owns the fetch PC and a hardware return-address stack.
// Sequences advance, relative jump, call and return; halt/resume and a sticky fault state.
module pc_sequencer #(
  parameter int unsigned AW    = 12,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SPW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          jump,
  input  logic          call,
  input  logic          ret,
  input  logic          halt,
  input  logic          resume,
  input  logic [AW-1:0] offset,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] stk0,
  output logic [SPW-1:0] sp,
  output logic          empty,
  output logic          full,
  output logic          halted,
  output logic          fault
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {StRun, StHalt, StFault} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  stack_q [DEPTH];
  logic           push;
  logic [AW-1:0]  push_val;
  logic [SPW-1:0] sp_m1;
  logic [AW-1:0]  top;

  assign sp_m1 = sp_q - SPW'(1);
  assign top   = stack_q[sp_m1[IW-1:0]];
  assign empty = (sp_q == '0);
  assign full  = (sp_q == SPW'(DEPTH));

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    sp_d     = sp_q;
    push     = 1'b0;
    push_val = pc_q + AW'(1);
    unique case (state_q)
      StRun: begin
        // Strobe priority: halt > ret > call > jump > sequential advance.
        if (en) begin
          if (halt) begin
            state_d = StHalt;
          end else if (ret) begin
            if (empty) begin
              state_d = StFault;
            end else begin
              pc_d = top;
              sp_d = sp_m1;
            end
          end else if (call) begin
            if (full) begin
              state_d = StFault;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SPW'(1);
              pc_d = pc_q + offset;
            end
          end else if (jump) begin
            pc_d = pc_q + offset;
          end else begin
            pc_d = pc_q + AW'(1);
          end
        end
      end
      StHalt: begin
        if (resume) state_d = StRun;
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= '0;
      sp_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      if (push) stack_q[sp_q[IW-1:0]] <= push_val;
    end
  end

  assign pc     = pc_q;
  assign sp     = sp_q;
  assign stk0   = empty ? '0 : top;
  assign halted = (state_q == StHalt);
  assign fault  = (state_q == StFault);

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-flow controller for the 12-bit instruction fetch path. Owns the program counter register and a hardware return-address stack, and sequences sequential advance, relative jump, call and return from decoded control strobes. Sits between the instruction decoder and instruction memory address port. Adds halt/resume and a latched fault state for stack overflow/underflow.

## Interface

Parameters:
- AW, 12, PC / address width; offsets and stack entries are AW bits.
- DEPTH, 8, return-stack entries; power of two, 2..16.
- SPW, 4, stack-count width; must satisfy 2^SPW > DEPTH.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; 0 = stall, all state held.
- jump  in  1  relative jump: pc <= pc + offset.
- call  in  1  push pc+1, then pc <= pc + offset.
- ret  in  1  pop: pc <= top of stack.
- halt  in  1  enter HALT at next edge.
- resume  in  1  leave HALT at next edge.
- offset  in  AW  two's-complement jump/call displacement.
- pc  out  AW  current fetch address (registered).
- stk0  out  AW  current top-of-stack entry; 0 when empty.
- sp  out  SPW  number of valid stack entries.
- empty  out  1  sp == 0.
- full  out  1  sp == DEPTH.
- halted  out  1  state == HALT.
- fault  out  1  state == FAULT (sticky).

## Operation

- States: RUN, HALT, FAULT. Reset state RUN.
- Reset values: pc=0, sp=0, stk0=0, empty=1, full=0, halted=0, fault=0; stack storage cleared to 0.
- RUN, per rising edge with en=1, priority highest first:
  - halt: go HALT; pc/stack unchanged; other strobes ignored.
  - ret: if empty, go FAULT, pc/sp unchanged; else pc <= stack[sp-1], sp <= sp-1.
  - call: if full, go FAULT, pc/sp unchanged; else stack[sp] <= pc+1, sp <= sp+1, pc <= pc+offset.
  - jump: pc <= pc+offset.
  - none: pc <= pc+1.
- RUN with en=0: nothing changes, regardless of strobes (halt included).
- HALT: pc, stack held; all strobes except resume ignored; resume=1 -> RUN at next edge (en not required). The first op in RUN is sampled on the edge after that.
- FAULT: everything held; exit only via rst.
- Arithmetic: all pc sums modulo 2^AW (wrap silently); offset sign-extended by width equality, i.e. plain AW-bit add. pc+1 pushed is also modulo 2^AW.
- Simultaneous call+ret: ret wins, no push. call+jump: call wins (same target, plus push). ret+jump: ret wins.
- stk0 = stack[sp-1] when sp>0 else 0; derived from registered state only.

## Timing

- pc, sp, state, stack update only on rising clk; all outputs are functions of registers (no input-to-output combinational path).
- Strobes sampled at edge N; new pc visible after edge N (one-cycle latency). Back-to-back ops every cycle supported.
- Push at edge N: stk0 shows pushed value after edge N. Pop at edge N: pc equals popped value after edge N.
- full/empty/sp settle with sp after the same edge.
- rst sampled on edges; overrides en, all strobes and every state; asserting mid-call/ret discards the op and returns all outputs to reset values after that edge.
- halted/fault assert in the cycle after the edge that causes the transition.

## Test plan

- Reset then 5 cycles en=1, no strobes -> pc 1,2,3,4,5; sp=0, empty=1; with en=0 for 2 cycles pc stays 5.
- pc=0x010, jump offset=0xFFE -> pc=0x00E; pc=0xFFF, no strobe -> pc=0x000 (wrap).
- pc=0x020, call offset=0x100 -> pc=0x120, sp=1, stk0=0x021; then ret -> pc=0x021, sp=0, stk0=0, empty=1.
- DEPTH=8: 8 calls -> full=1, sp=8; 9th call -> fault=1, pc and sp unchanged; further strobes ignored; rst -> pc=0, fault=0.
- ret with empty stack -> fault=1, pc unchanged; call+ret same cycle with sp=1 -> pop only, sp=0.
- halt with jump in same cycle -> halted=1, pc unchanged; strobes for 3 cycles ignored; resume -> halted=0 next edge, then pc increments from the held value.
